alu_op_scheduler: RTL and testbench

- Shares one non-pipelined ALU (op/a/b in via ready/valid, done/result out) between NUM_REQ requesters.
- Round-robin arbitration; exactly one ALU operation in flight at a time.
- Result goes back to the originating requester, tagged with its index.
- Per-op watchdog catches an ALU that never asserts done.

---
 rtl/alu_op_scheduler_pkg.sv | 25 ++
 rtl/alu_op_scheduler_if.sv | 52 +++++
 rtl/alu_op_scheduler_rr_arbiter.sv | 37 +++
 rtl/alu_op_scheduler.sv | 150 +++++++++++++++
 tb/tb_alu_op_scheduler.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_scheduler_pkg.sv
// Shared types for the ALU op scheduler: opcodes, FSM state names, result width helper.
// No logic here; imported by the interface, arbiter and top.
package alu_sched_pkg;

   typedef enum logic [2:0] {
      no_op  = 3'b000,
      add_op = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul_op = 3'b100,
      rst_op = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RESP      = 2'd3
   } sched_state_e;

   function automatic int result_w(input int data_w);
      return 2 * data_w;
   endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Requester, ALU and response buses of the scheduler bundled in one interface.
// slave = scheduler view, master = surrounding requesters/ALU/response sink.
// Handshakes are valid/ready; alu_done is a single-cycle pulse with no ready.
interface alu_op_scheduler_if
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
) ();
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int RES_W = result_w(DATA_W);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*3-1:0]      req_op;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;

   logic                      alu_valid;
   logic                      alu_ready;
   logic [2:0]                alu_op;
   logic [DATA_W-1:0]         alu_a;
   logic [DATA_W-1:0]         alu_b;
   logic                      alu_done;
   logic [RES_W-1:0]          alu_result;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [RES_W-1:0]          rsp_result;
   logic                      rsp_err;
   logic                      spurious_done;

   modport slave (
      input  req_valid, req_op, req_a, req_b,
      output req_ready,
      output alu_valid, alu_op, alu_a, alu_b,
      input  alu_ready, alu_done, alu_result,
      output rsp_valid, rsp_id, rsp_result, rsp_err, spurious_done,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_op, req_a, req_b,
      input  req_ready,
      input  alu_valid, alu_op, alu_a, alu_b,
      output alu_ready, alu_done, alu_result,
      input  rsp_valid, rsp_id, rsp_result, rsp_err, spurious_done,
      output rsp_ready
   );

endinterface

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// Round-robin pick: first set req bit at or above ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is consumed.
module rr_arbiter
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   logic [ID_W:0] sum;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (ID_W+1)'(i);
         if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
         end
         if (!any && req[sum[ID_W-1:0]]) begin
            any                   = 1'b1;
            idx                   = sum[ID_W-1:0];
            grant[sum[ID_W-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one non-pipelined ALU among NUM_REQ requesters, round-robin, one op in flight.
// Latency: grant -> alu_valid 1 cycle; ALU handshake/done -> rsp_valid 1 cycle.
// Backpressure: alu_ready stalls ISSUE, rsp_ready stalls RESP; no new grant until the response is taken.
module alu_op_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst_n,
   alu_op_scheduler_if.slave bus
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int RES_W = result_w(DATA_W);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ISSUE = ISSUE;
   localparam logic [1:0] ST_WAIT  = WAIT_DONE;
   localparam logic [1:0] ST_RESP  = RESP;

   typedef struct packed {
      logic [2:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } op_dat_t;

   logic [1:0]         state;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    rr_nxt;
   logic [ID_W-1:0]    id_q;
   logic [NUM_REQ-1:0] gnt_oh;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   op_dat_t            sel_dat;
   op_dat_t            op_q;
   logic [15:0]        wd_cnt;
   logic               alu_valid_q;
   logic               rsp_valid_q;
   logic               rsp_err_q;
   logic [RES_W-1:0]   rsp_result_q;
   logic               spurious_q;
   logic               no_done_op;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (gnt_oh),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   always_comb begin
      sel_dat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_oh[i]) begin
            sel_dat.op = bus.req_op[i*3 +: 3];
            sel_dat.a  = bus.req_a[i*DATA_W +: DATA_W];
            sel_dat.b  = bus.req_b[i*DATA_W +: DATA_W];
         end
      end
   end

   assign rr_nxt     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   // The ALU never raises done for these two, so they complete on acceptance.
   assign no_done_op = (op_q.op == no_op) || (op_q.op == rst_op);

   // Grant is only offered while idle; gated by reset so the pulse cannot leak during reset.
   assign bus.req_ready = (rst_n && state == ST_IDLE) ? gnt_oh : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         rr_ptr       <= '0;
         id_q         <= '0;
         op_q         <= '0;
         wd_cnt       <= '0;
         alu_valid_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_result_q <= '0;
         spurious_q   <= 1'b0;
      end else begin
         if (bus.alu_done && state != ST_WAIT) begin
            spurious_q <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (gnt_any) begin
                  op_q        <= sel_dat;
                  id_q        <= gnt_idx;
                  rr_ptr      <= rr_nxt;
                  alu_valid_q <= 1'b1;
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (bus.alu_ready) begin
                  alu_valid_q <= 1'b0;
                  if (no_done_op) begin
                     rsp_valid_q  <= 1'b1;
                     rsp_result_q <= '0;
                     rsp_err_q    <= 1'b0;
                     state        <= ST_RESP;
                  end else begin
                     wd_cnt <= '0;
                     state  <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // done is checked first so it wins a tie with the watchdog.
               if (bus.alu_done) begin
                  rsp_valid_q  <= 1'b1;
                  rsp_result_q <= bus.alu_result;
                  rsp_err_q    <= 1'b0;
                  state        <= ST_RESP;
               end else if (wd_cnt == 16'(TIMEOUT)) begin
                  rsp_valid_q  <= 1'b1;
                  rsp_result_q <= '0;
                  rsp_err_q    <= 1'b1;
                  state        <= ST_RESP;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.alu_valid     = alu_valid_q;
   assign bus.alu_op        = op_q.op;
   assign bus.alu_a         = op_q.a;
   assign bus.alu_b         = op_q.b;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_id        = id_q;
   assign bus.rsp_result    = rsp_result_q;
   assign bus.rsp_err       = rsp_err_q;
   assign bus.spurious_done = spurious_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: directed scenarios plus random traffic checked against
// a pending-request model (round-robin pick, ALU arithmetic, watchdog timing).
module tb_alu_op_scheduler;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int RW = 2 * DW;
   localparam int TO = 10;

   logic clk = 1'b0;
   logic rst_n;
   int   n_assert = 0;
   int   n_fail   = 0;

   bit            pend [NR];
   logic [2:0]    p_op [NR];
   logic [DW-1:0] p_a  [NR];
   logic [DW-1:0] p_b  [NR];
   int            m_ptr = 0;
   int            last_id;
   logic [RW-1:0] last_res;
   int            g;

   alu_op_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus_if ();

   alu_op_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      case (op)
         3'b001:  return RW'(a) + RW'(b);
         3'b010:  return RW'(a & b);
         3'b011:  return RW'(a ^ b);
         3'b100:  return RW'(a) * RW'(b);
         default: return '0;
      endcase
   endfunction

   function automatic int exp_grant();
      for (int i = 0; i < NR; i++) begin
         if (pend[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
      end
      return -1;
   endfunction

   function automatic bit any_pending();
      for (int i = 0; i < NR; i++) if (pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [2:0] rand_op();
      int k;
      k = $urandom_range(0, 5);
      return (k == 5) ? 3'b111 : 3'(k);
   endfunction

   task automatic set_req(input int i, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      pend[i] = 1'b1;
      p_op[i] = op;
      p_a[i]  = a;
      p_b[i]  = b;
   endtask

   task automatic add_rand_pending();
      for (int i = 0; i < NR; i++) begin
         if (!pend[i] && $urandom_range(0, 1) == 1) set_req(i, rand_op(), DW'($urandom), DW'($urandom));
      end
      if (!any_pending()) set_req($urandom_range(0, NR-1), rand_op(), DW'($urandom), DW'($urandom));
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NR; i++) begin
         bus_if.req_valid[i]         = pend[i];
         bus_if.req_op[i*3 +: 3]     = p_op[i];
         bus_if.req_a[i*DW +: DW]    = p_a[i];
         bus_if.req_b[i*DW +: DW]    = p_b[i];
      end
   endtask

   // One full transaction for the model's next winner, with the given stall lengths.
   task automatic do_txn(input int rdy_dly, input int done_dly, input int rsp_dly);
      int            gi;
      int            cnt;
      logic [2:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [RW-1:0] exp_res;
      logic [RW-1:0] alu_res;
      gi = exp_grant();
      if (gi < 0) return;
      op      = p_op[gi];
      a       = p_a[gi];
      b       = p_b[gi];
      exp_res = alu_ref(op, a, b);
      drive_reqs();
      #1;
      cnt = 0;
      while (bus_if.req_ready == '0 && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("grant_vec", 32'(bus_if.req_ready), 32'(1) << gi);
      @(posedge clk); #1;
      pend[gi] = 1'b0;
      drive_reqs();
      chk("ready_pulse", 32'(bus_if.req_ready), 32'(0));
      for (int k = 0; k <= rdy_dly; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            chk("issue_no_grant", 32'(bus_if.req_ready), 32'(0));
         end
         chk("alu_valid", 32'(bus_if.alu_valid), 32'(1));
         chk("alu_op", 32'(bus_if.alu_op), 32'(op));
         chk("alu_a", 32'(bus_if.alu_a), 32'(a));
         chk("alu_b", 32'(bus_if.alu_b), 32'(b));
      end
      alu_res = alu_ref(bus_if.alu_op, bus_if.alu_a, bus_if.alu_b);
      bus_if.alu_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.alu_ready = 1'b0;
      if (op != 3'b000 && op != 3'b111) begin
         for (int k = 1; k < done_dly; k++) begin
            chk("wait_no_rsp", 32'(bus_if.rsp_valid), 32'(0));
            @(posedge clk); #1;
         end
         bus_if.alu_done   = 1'b1;
         bus_if.alu_result = alu_res;
         @(posedge clk); #1;
         bus_if.alu_done   = 1'b0;
         bus_if.alu_result = RW'($urandom);
      end
      for (int k = 0; k <= rsp_dly; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            chk("resp_no_grant", 32'(bus_if.req_ready), 32'(0));
         end
         chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(1));
         chk("rsp_id", 32'(bus_if.rsp_id), 32'(gi));
         chk("rsp_result", 32'(bus_if.rsp_result), 32'(exp_res));
         chk("rsp_err", 32'(bus_if.rsp_err), 32'(0));
      end
      chk("alu_idle_in_resp", 32'(bus_if.alu_valid), 32'(0));
      last_id  = int'(bus_if.rsp_id);
      last_res = bus_if.rsp_result;
      bus_if.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.rsp_ready = 1'b0;
      chk("rsp_dropped", 32'(bus_if.rsp_valid), 32'(0));
      m_ptr = (gi + 1) % NR;
   endtask

   initial begin
      logic [RW-1:0] rr_exp [NR];
      rr_exp = '{16'd6, 16'd20, 16'd42, 16'd72};

      rst_n             = 1'b0;
      bus_if.req_valid  = '0;
      bus_if.req_op     = '0;
      bus_if.req_a      = '0;
      bus_if.req_b      = '0;
      bus_if.alu_ready  = 1'b0;
      bus_if.alu_done   = 1'b0;
      bus_if.alu_result = '0;
      bus_if.rsp_ready  = 1'b0;
      for (int i = 0; i < NR; i++) set_req(i, 3'b000, '0, '0);
      for (int i = 0; i < NR; i++) pend[i] = 1'b0;
      #1;
      chk("rst_alu_valid", 32'(bus_if.alu_valid), 32'(0));
      chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'(0));
      chk("rst_req_ready", 32'(bus_if.req_ready), 32'(0));
      chk("rst_spurious", 32'(bus_if.spurious_done), 32'(0));
      chk("rst_rsp_id", 32'(bus_if.rsp_id), 32'(0));
      chk("rst_rsp_result", 32'(bus_if.rsp_result), 32'(0));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Round-robin: all four valid with multiplies.
      for (int i = 0; i < NR; i++) set_req(i, 3'b100, DW'(2*i + 2), DW'(2*i + 3));
      for (int i = 0; i < NR; i++) begin
         do_txn(0, 2, 0);
         chk("rr_id", 32'(last_id), 32'(i));
         chk("rr_result", 32'(last_res), 32'(rr_exp[i]));
      end

      // Single add with pointer wrapped back to 0; req3 also waiting.
      set_req(0, 3'b001, 8'h12, 8'h34);
      set_req(3, 3'b011, 8'h5a, 8'h0f);
      do_txn(0, 3, 0);
      chk("add_id", 32'(last_id), 32'(0));
      chk("add_result", 32'(last_res), 32'(16'h0046));

      // rst_op from req2 completes on acceptance.
      set_req(2, 3'b111, 8'hff, 8'hff);
      do_txn(0, 1, 0);
      chk("rstop_id", 32'(last_id), 32'(2));
      chk("rstop_result", 32'(last_res), 32'(0));
      chk("rstop_no_spurious", 32'(bus_if.spurious_done), 32'(0));

      // Backpressure on both the ALU and response sides.
      add_rand_pending();
      do_txn(5, 2, 4);
      while (any_pending()) do_txn(0, 1, 0);

      // done arriving on the very cycle the watchdog expires still wins.
      set_req(1, 3'b100, 8'd11, 8'd13);
      do_txn(0, TO + 1, 0);
      chk("tie_result", 32'(last_res), 32'(143));

      for (int n = 0; n < 40; n++) begin
         add_rand_pending();
         do_txn($urandom_range(0, 4), $urandom_range(1, 5), $urandom_range(0, 3));
      end
      while (any_pending()) do_txn(0, 1, 0);
      chk("no_spurious_yet", 32'(bus_if.spurious_done), 32'(0));

      // Watchdog abort: no done ever comes.
      set_req(1, 3'b100, 8'd7, 8'd9);
      g = exp_grant();
      drive_reqs();
      #1;
      chk("to_grant", 32'(bus_if.req_ready), 32'(1) << g);
      @(posedge clk); #1;
      pend[g] = 1'b0;
      drive_reqs();
      bus_if.alu_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.alu_ready = 1'b0;
      for (int k = 1; k <= TO + 1; k++) begin
         @(posedge clk); #1;
         if (k <= TO) chk("to_early", 32'(bus_if.rsp_valid), 32'(0));
      end
      chk("to_valid", 32'(bus_if.rsp_valid), 32'(1));
      chk("to_err", 32'(bus_if.rsp_err), 32'(1));
      chk("to_result", 32'(bus_if.rsp_result), 32'(0));
      chk("to_id", 32'(bus_if.rsp_id), 32'(g));
      bus_if.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.rsp_ready = 1'b0;
      m_ptr = (g + 1) % NR;
      chk("to_no_spurious", 32'(bus_if.spurious_done), 32'(0));
      bus_if.alu_done = 1'b1;
      @(posedge clk); #1;
      bus_if.alu_done = 1'b0;
      chk("late_done_spurious", 32'(bus_if.spurious_done), 32'(1));

      // Async reset while an op waits for done.
      set_req(2, 3'b001, 8'd1, 8'd2);
      drive_reqs();
      @(posedge clk); #1;
      pend[2] = 1'b0;
      drive_reqs();
      bus_if.alu_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.alu_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) set_req(i, rand_op(), DW'($urandom), DW'($urandom));
      drive_reqs();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_alu_valid", 32'(bus_if.alu_valid), 32'(0));
      chk("arst_rsp_valid", 32'(bus_if.rsp_valid), 32'(0));
      chk("arst_req_ready", 32'(bus_if.req_ready), 32'(0));
      chk("arst_spurious", 32'(bus_if.spurious_done), 32'(0));
      chk("arst_alu_a", 32'(bus_if.alu_a), 32'(0));
      @(posedge clk); #1;
      chk("arst_hold_ready", 32'(bus_if.req_ready), 32'(0));
      rst_n = 1'b1;
      m_ptr = 0;
      chk("arst_no_old_rsp", 32'(bus_if.rsp_valid), 32'(0));
      do_txn(0, 2, 0);
      chk("arst_first_id", 32'(last_id), 32'(0));
      while (any_pending()) do_txn(0, 2, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
